// File: rtl/fb_pkg.sv
// Framebuffer geometry, widths and shared types for the scan arbiter slice.
package fb_pkg;

  localparam int SRC_W      = 160;
  localparam int SRC_H      = 120;
  localparam int SCALE      = 4;
  localparam int SCALE_LOG2 = $clog2(SCALE);
  localparam int PIX_W      = 3;
  localparam int ADDR_W     = 15;
  localparam int ACTIVE_W   = SRC_W * SCALE;
  localparam int ACTIVE_H   = SRC_H * SCALE;
  localparam int FB_DEPTH   = SRC_W * SRC_H;
  localparam int COORD_W    = 10;
  localparam int COL_W      = $clog2(SRC_W + 1);

  typedef logic [PIX_W-1:0]   fb_pix_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COORD_W-1:0] fb_coord_t;

  typedef enum logic {
    ST_WAIT_SYNC,
    ST_ACTIVE
  } fb_state_t;

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Source-address generation for scan-out: column/sub-line/row-base counters
// and the decode of which pixel-clock cycles belong to the video read slot.
module fb_scan_addr_gen
  import fb_pkg::*;
(
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic               scan_en,
  input  logic               sync,
  output logic               in_active,
  output logic               video_slot,
  output logic [ADDR_W-1:0]  rd_addr
);

  logic [COL_W-1:0]      col;
  logic [SCALE_LOG2-1:0] sub_line;
  fb_addr_t              row_base;
  logic                  line_end;

  // The frame origin always reads address 0, even on the cycle that brings
  // the FSM out of WAIT_SYNC, so the first pixel of a re-synced frame is valid.
  always_comb begin
    in_active  = (cx < COORD_W'(ACTIVE_W)) && (cy < COORD_W'(ACTIVE_H));
    video_slot = (scan_en || sync) && in_active && (cx[SCALE_LOG2-1:0] == '0);
    line_end   = scan_en && (cx == COORD_W'(ACTIVE_W - 1)) && (cy < COORD_W'(ACTIVE_H));
    rd_addr    = sync ? '0 : row_base + ADDR_W'(col);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      col      <= '0;
      sub_line <= '0;
      row_base <= '0;
    end else if (sync) begin
      col      <= COL_W'(1);
      sub_line <= '0;
      row_base <= '0;
    end else if (line_end) begin
      col      <= '0;
      sub_line <= sub_line + SCALE_LOG2'(1);
      if (sub_line == SCALE_LOG2'(SCALE - 1))
        row_base <= row_base + ADDR_W'(SRC_W);
    end else if (video_slot) begin
      col <= col + COL_W'(1);
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: 1-in-4 scan-out read slots, all other cycles
// serve the writer. Optional write-stall counter enabled by FB_WR_STALL_CNT_EN.
module fb_scan_arbiter
  import fb_pkg::*;
(
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  output logic               wr_drop,
  output logic               ram_ce,
  output logic               ram_wre,
  output logic [ADDR_W-1:0]  ram_ad,
  output logic [PIX_W-1:0]   ram_din,
  input  logic [PIX_W-1:0]   ram_dout,
  output logic [PIX_W-1:0]   pix_rgb,
  output logic               frame_start,
  output logic [15:0]        stall_cnt
);

  fb_state_t state_q, state_d;
  logic      sync, scan_en, in_active, video_slot, wr_in_range;
  fb_addr_t  rd_addr;
  logic      rd_d1;
  logic [1:0] act_pipe;
  fb_pix_t   pix_q;

  assign sync    = (cx == '0) && (cy == '0);
  assign scan_en = (state_q == ST_ACTIVE);

  fb_scan_addr_gen u_addr_gen (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .cx         (cx),
    .cy         (cy),
    .scan_en    (scan_en),
    .sync       (sync),
    .in_active  (in_active),
    .video_slot (video_slot),
    .rd_addr    (rd_addr)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) state_q <= ST_WAIT_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sync) state_d = ST_ACTIVE;
  end

  // Read and write never share a cycle: a read slot simply withholds wr_ready.
  always_comb begin
    wr_ready    = !video_slot;
    wr_in_range = wr_addr < ADDR_W'(FB_DEPTH);
    ram_ce      = 1'b0;
    ram_wre     = 1'b0;
    ram_ad      = wr_addr;
    ram_din     = wr_data;
    wr_drop     = 1'b0;
    if (!reset) begin
      if (video_slot) begin
        ram_ce = 1'b1;
        ram_ad = rd_addr;
      end else if (wr_valid) begin
        if (wr_in_range) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
        end else begin
          wr_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rd_d1       <= 1'b0;
      act_pipe    <= '0;
      pix_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      rd_d1       <= video_slot;
      act_pipe    <= {act_pipe[0], (scan_en || sync) && in_active};
      frame_start <= sync;
      if (rd_d1) pix_q <= ram_dout;
    end
  end

  assign pix_rgb = (act_pipe[1] && !reset) ? pix_q : '0;

`ifdef FB_WR_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_pixel) begin
    if (reset || frame_start)
      stall_q <= '0;
    else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule
